serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller: accepts two signed WIDTH-bit operands plus carry-in over a valid/ready handshake and sequences a single instance of the team's 1-bit `fulladder` across all bit positions, LSB first. It returns sum, carry-out and signed-overflow over a second valid/ready handshake. It is the area-minimal adder for LDPC check/variable-node message accumulation, where one full-adder cell per node is shared over WIDTH cycles.

## Interface
- `WIDTH`, 8, operand/sum width in bits; legal range 2..32.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: controller can accept operands.
- `a` in WIDTH: operand A, two's complement.
- `b` in WIDTH: operand B, two's complement.
- `cin` in 1: carry-in, captured with the operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `sum` out WIDTH: result.
- `cout` out 1: carry out of bit WIDTH-1.
- `ovf` out 1: signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready` at an edge:
  - load `a` and `b` into shift registers;
  - load the carry register with `cin`;
  - clear the bit counter;
  - enter RUN.
- RUN: each cycle, `fulladder` X/Y = shift-register LSBs, C_in = carry register.
  - On the edge: S shifts into the MSB of the sum register (right shift), C_out loads the carry register, and the operand registers shift right.
  - The carry into bit WIDTH-1 is saved for `ovf`.
  - After WIDTH such cycles (counter reaches WIDTH-1), enter DONE.
- DONE: `out_valid`=1; `sum`, `cout` and `ovf` are stable.
  - On `out_valid`&`out_ready`, return to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` is ignored in RUN/DONE.
- `sum`, `cout` and `ovf` are registered. They are meaningful only while `out_valid`=1, hold after the handshake, and change during RUN.
- Counter width: clog2(WIDTH). No arithmetic is wider than 1 bit; the only adder is the `fulladder` instance.
- Reset (any state, any time): state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, shift/carry/counter registers=0. An operation in flight is discarded and no result is emitted.

## Timing
- Accept edge E0. RUN occupies the cycles after E0, E0+1 … E0+WIDTH-1; `out_valid` rises after edge E0+WIDTH (latency WIDTH cycles).
- With `out_ready`=1 held, DONE lasts one cycle: IDLE after E0+WIDTH+1, next accept at E0+WIDTH+2. Max throughput is one add per WIDTH+2 cycles.
- `out_ready` low: DONE holds indefinitely and outputs do not change.
- `in_ready` and `out_valid` are decoded directly from registered state, with no combinational path from `in_valid`/`out_ready`.
- Async reset takes effect immediately; `in_ready`=1 while `rst` is high.

## Configuration
- `SERIAL_ADD_SAT_EN` defined: when overflow is detected at the end of RUN, `sum` is clamped on the DONE load.
  - Positive overflow (both operand MSBs 0) gives 0111…1.
  - Negative overflow gives 1000…0.
  - `ovf`=1 and `cout` is unmodified. Operand MSBs are captured at accept for this purpose.
- Undefined: `sum` is the raw modulo-2^WIDTH result; `ovf` is still reported. No other behaviour differs.

## Test plan
- WIDTH=8: `a`=0x05, `b`=0x03, `cin`=0 accepted at E0 -> `out_valid` first high after E0+8, `sum`=0x08, `cout`=0, `ovf`=0.
- `a`=0x7F, `b`=0x01, `cin`=0 -> `ovf`=1, `cout`=0.
  - Macro undefined: `sum`=0x80.
  - `SERIAL_ADD_SAT_EN`: `sum`=0x7F.
- `a`=0x80, `b`=0xFF, `cin`=0 -> `ovf`=1, `cout`=1.
  - Macro undefined: `sum`=0x7F.
  - `SERIAL_ADD_SAT_EN`: `sum`=0x80.
- `a`=0xFF, `b`=0x00, `cin`=1 -> `sum`=0x00, `cout`=1, `ovf`=0 in both builds.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new operands.
  - Required: `out_valid`=1, `sum` stable, `in_ready`=0, new operands not captured.
  - Then set `out_ready`=1: handshake, IDLE next cycle, new operands accepted on the following edge. Accept-to-accept interval with `out_ready`=1 is exactly 10 cycles.
- Assert `rst` asynchronously 3 cycles into RUN -> outputs and state reset immediately, `in_ready`=1 during reset, no `out_valid` pulse. A subsequent 0x10+0x22 gives `sum`=0x32.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial two's-complement adder. A single 1-bit fulladder cell is shared
// over WIDTH cycles, one bit per cycle, LSB first. Operands arrive over one
// valid/ready handshake and the result leaves over a second one.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   controller idle and able to accept operands
//   a, b       WIDTH-bit two's-complement operands
//   cin        carry-in, captured with the operands
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result (registered)
//   cout       carry out of bit WIDTH-1 (registered)
//   ovf        signed overflow (registered)
//
// Build option
//   SERIAL_ADD_SAT_EN  when defined, an overflowing sum is clamped to the
//                      most positive / most negative value. ovf and cout
//                      are reported identically in both builds.
// ---------------------------------------------------------------------------

module fulladder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

`ifdef SERIAL_ADD_SAT_EN
    // Sign of operand A at accept. Overflow only happens when both operands
    // share a sign, so A's MSB alone picks the clamp direction.
    logic             a_msb;
`endif

    logic fa_s;
    logic fa_co;

    fulladder u_fa (
        .x     (a_sh[0]),
        .y     (b_sh[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_co)
    );

    // Handshake flags come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
`ifdef SERIAL_ADD_SAT_EN
            a_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
`ifdef SERIAL_ADD_SAT_EN
                        a_msb <= a[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    // New bit enters at the MSB; after WIDTH shifts bit 0
                    // sits in sum[0].
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        // On the MSB cycle the carry register holds the
                        // carry into bit WIDTH-1, fa_co the carry out of it.
                        cout  <= fa_co;
                        ovf   <= carry ^ fa_co;
                        state <= DONE;
`ifdef SERIAL_ADD_SAT_EN
                        if (carry ^ fa_co)
                            sum <= a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl (WIDTH=8). Directed vectors plus
// randomized operands and backpressure, checked against an arithmetic
// reference model. Also exercises asynchronous reset mid-operation.
// ---------------------------------------------------------------------------

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_acc = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  input logic xc, output logic [W-1:0] es,
                                  output logic ec, output logic eo);
        longint ua, ub, uc, u, sa, sb, s, smax, smin;
        ua = longint'(xa);
        ub = longint'(xb);
        uc = xc ? 64'sd1 : 64'sd0;
        u  = ua + ub + uc;
        ec = (u >= (64'sd1 <<< W));
        es = W'(u);
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        s  = sa + sb + uc;
        smax = (64'sd1 <<< (W - 1)) - 1;
        smin = -(64'sd1 <<< (W - 1));
        eo = (s > smax) || (s < smin);
`ifdef SERIAL_ADD_SAT_EN
        if (eo) es = (s > 0) ? W'(smax) : W'(smin);
`endif
    endfunction

    // One full transaction. stall = cycles DONE is held with out_ready low
    // while junk operands are driven. b2b requests an accept-to-accept check.
    task automatic do_add(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input int stall, input bit b2b);
        logic [W-1:0] es;
        logic         ec, eo;
        int           n;
        model(xa, xb, xc, es, ec, eo);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_idle", in_ready, 1);
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        if (b2b) chk("accept_interval", cyc - last_acc, W + 2);
        last_acc = cyc;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk("in_ready_run", in_ready, 0);
        for (int i = 1; i < W; i++) begin
            // Stray in_valid during RUN must be ignored.
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("out_valid_early", out_valid, 0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("out_valid_done", out_valid, 1);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo);
        if (stall > 0) begin
            in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                @(posedge clk); #1;
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", sum, es);
                chk("hold_flags", {cout, ovf}, {ec, eo});
                chk("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
        // Handshake edge; in_valid (if still high) is ignored in DONE.
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("back_to_idle", {in_ready, out_valid}, 2'b10);
        chk("post_hs_sum", sum, es);
    endtask

    initial begin
        bit seen_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {sum, cout, ovf}, '0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Directed vectors.
        do_add(8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_add(8'h7F, 8'h01, 1'b0, 0, 1'b1);
        do_add(8'h80, 8'hFF, 1'b0, 0, 1'b1);
        do_add(8'hFF, 8'h00, 1'b1, 5, 1'b1);
        do_add(8'h12, 8'h34, 1'b0, 0, 1'b0);

        // Async reset three cycles into RUN.
        a = 8'h55; b = 8'h66; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_outputs", {sum, cout, ovf}, '0);
        @(posedge clk); #1;
        chk("mid_rst_hold", {in_ready, out_valid}, 2'b10);
        #2 rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        chk("no_valid_after_rst", seen_valid, 0);
        do_add(8'h10, 8'h22, 1'b0, 0, 1'b0);

        // Random traffic, some with backpressure.
        for (int t = 0; t < 40; t++) begin
            int st;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_add(W'($urandom), W'($urandom), 1'($urandom), st, 1'b0);
        end
        // Boundary operands.
        do_add(8'h80, 8'h80, 1'b0, 0, 1'b0);
        do_add(8'h7F, 8'h7F, 1'b1, 0, 1'b1);
        do_add(8'hFF, 8'hFF, 1'b1, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
